// File: rtl/spectag_unit_pkg.sv
// Shared core constants for the speculative-tag unit: tag count, decode width,
// and the branch-result bus layout.
package spectag_unit_pkg;

  localparam int SPEC_STATES      = 4;
  localparam int CORE_DECODE_RATE = 2;

  // Branch result bus: {SPECTAG, ISSPEC, MISPRED, VALID}
  localparam int FUBR_RESULT_VALID   = 0;
  localparam int FUBR_RESULT_MISPRED = 1;
  localparam int FUBR_RESULT_ISSPEC  = 2;
  localparam int FUBR_RESULT_SPECTAG = 3;
  localparam int FUBR_RESULT_LEN     = FUBR_RESULT_SPECTAG + SPEC_STATES;

endpackage

// File: rtl/spectag_unit_free_finder.sv
// Picks the lowest-index DECODE_RATE free tags as one-hot slots.
// Unfilled slots read as zero with their valid bit low.
module spectag_free_finder #(
  parameter int SPECTAGS    = 4,
  parameter int DECODE_RATE = 2
) (
  input  logic [SPECTAGS-1:0]             i_valid,
  output logic [DECODE_RATE*SPECTAGS-1:0] o_tags,
  output logic [DECODE_RATE-1:0]          o_vld
);

  always_comb begin
    int cnt;
    o_tags = '0;
    o_vld  = '0;
    cnt    = 0;
    for (int i = 0; i < SPECTAGS; i++) begin
      if (!i_valid[i]) begin
        for (int k = 0; k < DECODE_RATE; k++) begin
          if (cnt == k) begin
            o_tags[k*SPECTAGS + i] = 1'b1;
            o_vld[k]               = 1'b1;
          end
        end
        cnt = cnt + 1;
      end
    end
  end

endmodule

// File: rtl/spectag_unit.sv
// Speculative branch-tag allocator with per-tag kill masks.
// Define SPECTAG_CHECK_EN to add simulation assertions on allocation/resolve inputs.
module spectag_unit
  import spectag_unit_pkg::*;
#(
  parameter int SPECTAGS    = SPEC_STATES,
  parameter int DECODE_RATE = CORE_DECODE_RATE
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            Flush,
  input  logic                            Stall,
  input  logic [DECODE_RATE-1:0]          Alloced_SpectagMask,
  input  logic [FUBR_RESULT_LEN-1:0]      FUBRresp,
  output logic [$clog2(SPECTAGS):0]       FreeSpectags,
  output logic [DECODE_RATE-1:0]          ToAlloc_SpectagValid,
  output logic [DECODE_RATE*SPECTAGS-1:0] ToAlloc_Spectags,
  output logic [DECODE_RATE*SPECTAGS-1:0] ToAlloc_KillMasks,
  output logic [SPECTAGS-1:0]             Spectag_Valid
);

  localparam int CNT_W = $clog2(SPECTAGS) + 1;

  logic [SPECTAGS-1:0]             r_valid;
  logic [SPECTAGS-1:0]             r_km       [SPECTAGS];
  logic [SPECTAGS-1:0]             w_valid_nxt;
  logic [SPECTAGS-1:0]             w_km_nxt   [SPECTAGS];
  logic [DECODE_RATE*SPECTAGS-1:0] w_tags;
  logic [DECODE_RATE*SPECTAGS-1:0] w_masks;
  logic [DECODE_RATE-1:0]          w_slot_vld;
  logic [CNT_W-1:0]                w_used;
  logic [SPECTAGS-1:0]             w_res_tag;
  logic [SPECTAGS-1:0]             w_kill;
  logic                            w_ok;
  logic                            w_mis;

  spectag_free_finder #(
    .SPECTAGS   (SPECTAGS),
    .DECODE_RATE(DECODE_RATE)
  ) u_finder (
    .i_valid(r_valid),
    .o_tags (w_tags),
    .o_vld  (w_slot_vld)
  );

  assign w_res_tag = FUBRresp[FUBR_RESULT_SPECTAG +: SPECTAGS];
  assign w_ok      = FUBRresp[FUBR_RESULT_VALID] & FUBRresp[FUBR_RESULT_ISSPEC]
                   & ~FUBRresp[FUBR_RESULT_MISPRED];
  assign w_mis     = FUBRresp[FUBR_RESULT_VALID] & FUBRresp[FUBR_RESULT_MISPRED];

  always_comb begin
    w_used = '0;
    for (int i = 0; i < SPECTAGS; i++) w_used = w_used + CNT_W'(r_valid[i]);
  end

  // Allocation view comes purely from registered state; resolutions land next cycle.
  assign FreeSpectags         = CNT_W'(SPECTAGS) - w_used;
  assign ToAlloc_SpectagValid = w_slot_vld;
  assign ToAlloc_Spectags     = w_tags;
  assign ToAlloc_KillMasks    = w_masks;
  assign Spectag_Valid        = r_valid;

  // Each slot is killed by everything outstanding plus every earlier slot in the group.
  always_comb begin
    logic [SPECTAGS-1:0] acc;
    w_masks = '0;
    acc     = r_valid;
    for (int k = 0; k < DECODE_RATE; k++) begin
      w_masks[k*SPECTAGS +: SPECTAGS] = acc;
      acc = acc | w_tags[k*SPECTAGS +: SPECTAGS];
    end
  end

  always_comb begin
    w_valid_nxt = r_valid;
    w_km_nxt    = r_km;
    w_kill      = '0;
    if (Flush) begin
      w_valid_nxt = '0;
      for (int i = 0; i < SPECTAGS; i++) w_km_nxt[i] = '0;
    end else if (w_mis) begin
      // Squash the mispredicted tag and every tag allocated under it.
      w_kill = w_res_tag;
      for (int i = 0; i < SPECTAGS; i++)
        if ((r_km[i] & w_res_tag) != '0) w_kill[i] = 1'b1;
      w_valid_nxt = r_valid & ~w_kill;
      for (int i = 0; i < SPECTAGS; i++)
        w_km_nxt[i] = w_kill[i] ? '0 : (r_km[i] & ~w_kill);
    end else begin
      if (w_ok) begin
        w_valid_nxt = r_valid & ~w_res_tag;
        for (int i = 0; i < SPECTAGS; i++) w_km_nxt[i] = r_km[i] & ~w_res_tag;
      end
      if (!Stall) begin
        for (int k = 0; k < DECODE_RATE; k++) begin
          if (Alloced_SpectagMask[k] && w_slot_vld[k]) begin
            w_valid_nxt = w_valid_nxt | w_tags[k*SPECTAGS +: SPECTAGS];
            for (int i = 0; i < SPECTAGS; i++)
              if (w_tags[k*SPECTAGS + i])
                w_km_nxt[i] = w_masks[k*SPECTAGS +: SPECTAGS] & ~(w_ok ? w_res_tag : '0);
          end
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_valid <= '0;
      for (int i = 0; i < SPECTAGS; i++) r_km[i] <= '0;
    end else begin
      r_valid <= w_valid_nxt;
      for (int i = 0; i < SPECTAGS; i++) r_km[i] <= w_km_nxt[i];
    end
  end

`ifdef SPECTAG_CHECK_EN
  always @(posedge clk) begin
    if (rst && !Stall && !Flush) begin
      assert ((Alloced_SpectagMask & (Alloced_SpectagMask + 1'b1)) == '0)
        else $error("spectag_unit: Alloced_SpectagMask not contiguous from bit 0: %b",
                    Alloced_SpectagMask);
      assert ((Alloced_SpectagMask & ~w_slot_vld) == '0)
        else $error("spectag_unit: allocation on invalid slot: alloc=%b valid=%b",
                    Alloced_SpectagMask, w_slot_vld);
    end
    if (rst && (w_ok || w_mis)) begin
      assert ($onehot(w_res_tag) && ((w_res_tag & r_valid) != '0))
        else $error("spectag_unit: bad resolve tag %b (valid=%b)", w_res_tag, r_valid);
    end
  end
`else
  // Default build carries no input checking.
`endif

endmodule

// File: tb/tb_spectag_unit.sv
// Directed self-checking bench for spectag_unit (default 4 tags, 2 slots).
module tb_spectag_unit;
  import spectag_unit_pkg::*;

  logic                       clk = 1'b0;
  logic                       rst = 1'b0;
  logic                       Flush = 1'b0;
  logic                       Stall = 1'b0;
  logic [1:0]                 Alloced = 2'b00;
  logic [FUBR_RESULT_LEN-1:0] FUBRresp = '0;
  logic [2:0]                 FreeSpectags;
  logic [1:0]                 ToAlloc_SpectagValid;
  logic [7:0]                 ToAlloc_Spectags;
  logic [7:0]                 ToAlloc_KillMasks;
  logic [3:0]                 Spectag_Valid;
  int                         total = 0;
  int                         bad = 0;

  spectag_unit dut (
    .clk                 (clk),
    .rst                 (rst),
    .Flush               (Flush),
    .Stall               (Stall),
    .Alloced_SpectagMask (Alloced),
    .FUBRresp            (FUBRresp),
    .FreeSpectags        (FreeSpectags),
    .ToAlloc_SpectagValid(ToAlloc_SpectagValid),
    .ToAlloc_Spectags    (ToAlloc_Spectags),
    .ToAlloc_KillMasks   (ToAlloc_KillMasks),
    .Spectag_Valid       (Spectag_Valid)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [FUBR_RESULT_LEN-1:0] resp(input bit mis, input logic [3:0] t);
    logic [FUBR_RESULT_LEN-1:0] r;
    r = '0;
    r[FUBR_RESULT_VALID]   = 1'b1;
    r[FUBR_RESULT_MISPRED] = mis;
    r[FUBR_RESULT_ISSPEC]  = 1'b1;
    r[FUBR_RESULT_SPECTAG +: 4] = t;
    return r;
  endfunction

  task automatic idle_inputs();
    Alloced = 2'b00; FUBRresp = '0; Stall = 1'b0; Flush = 1'b0;
  endtask

  task automatic do_flush();
    Flush = 1'b1; tick(); idle_inputs();
  endtask

  task automatic alloc(input logic [1:0] m);
    Alloced = m; tick(); idle_inputs();
  endtask

  task automatic test_reset();
    rst = 1'b0; idle_inputs();
    repeat (2) @(posedge clk);
    #1;
    total++; if (Spectag_Valid !== 4'b0000) begin bad++; $display("FAIL reset_valid got=%b exp=0000", Spectag_Valid); end
    rst = 1'b1;
    tick();
    total++; if (FreeSpectags !== 3'd4) begin bad++; $display("FAIL reset_free got=%0d exp=4", FreeSpectags); end
    total++; if (ToAlloc_Spectags !== 8'b0010_0001) begin bad++; $display("FAIL reset_tags got=%b exp=00100001", ToAlloc_Spectags); end
    total++; if (ToAlloc_KillMasks !== 8'b0001_0000) begin bad++; $display("FAIL reset_masks got=%b exp=00010000", ToAlloc_KillMasks); end
    total++; if (ToAlloc_SpectagValid !== 2'b11) begin bad++; $display("FAIL reset_slotvld got=%b exp=11", ToAlloc_SpectagValid); end
  endtask

  task automatic test_alloc();
    alloc(2'b11);
    total++; if (Spectag_Valid !== 4'b0011) begin bad++; $display("FAIL alloc_valid got=%b exp=0011", Spectag_Valid); end
    total++; if (FreeSpectags !== 3'd2) begin bad++; $display("FAIL alloc_free got=%0d exp=2", FreeSpectags); end
    total++; if (ToAlloc_Spectags !== 8'b1000_0100) begin bad++; $display("FAIL alloc_tags got=%b exp=10000100", ToAlloc_Spectags); end
    total++; if (ToAlloc_KillMasks !== 8'b0111_0011) begin bad++; $display("FAIL alloc_masks got=%b exp=01110011", ToAlloc_KillMasks); end
    total++; if (dut.r_km[1] !== 4'b0001) begin bad++; $display("FAIL alloc_km1 got=%b exp=0001", dut.r_km[1]); end
  endtask

  task automatic test_correct_resolve();
    FUBRresp = resp(1'b0, 4'b0001); tick(); idle_inputs();
    total++; if (Spectag_Valid !== 4'b0010) begin bad++; $display("FAIL cres_valid got=%b exp=0010", Spectag_Valid); end
    total++; if (dut.r_km[1] !== 4'b0000) begin bad++; $display("FAIL cres_km1 got=%b exp=0000", dut.r_km[1]); end
    total++; if (ToAlloc_Spectags !== 8'b0100_0001) begin bad++; $display("FAIL cres_tags got=%b exp=01000001", ToAlloc_Spectags); end
    total++; if (ToAlloc_KillMasks !== 8'b0011_0010) begin bad++; $display("FAIL cres_masks got=%b exp=00110010", ToAlloc_KillMasks); end
    total++; if (FreeSpectags !== 3'd3) begin bad++; $display("FAIL cres_free got=%0d exp=3", FreeSpectags); end
  endtask

  task automatic test_mispredict();
    do_flush();
    total++; if (Spectag_Valid !== 4'b0000) begin bad++; $display("FAIL mis_flush got=%b exp=0000", Spectag_Valid); end
    alloc(2'b11);
    alloc(2'b01);
    total++; if (Spectag_Valid !== 4'b0111) begin bad++; $display("FAIL mis_setup got=%b exp=0111", Spectag_Valid); end
    total++; if (dut.r_km[2] !== 4'b0011) begin bad++; $display("FAIL mis_km2 got=%b exp=0011", dut.r_km[2]); end
    // allocations in the same cycle as a mispredict must be dropped
    Alloced = 2'b01; FUBRresp = resp(1'b1, 4'b0010); tick(); idle_inputs();
    total++; if (Spectag_Valid !== 4'b0001) begin bad++; $display("FAIL mis_valid got=%b exp=0001", Spectag_Valid); end
    total++; if (FreeSpectags !== 3'd3) begin bad++; $display("FAIL mis_free got=%0d exp=3", FreeSpectags); end
  endtask

  task automatic test_full();
    do_flush();
    alloc(2'b11);
    alloc(2'b11);
    total++; if (Spectag_Valid !== 4'b1111) begin bad++; $display("FAIL full_valid got=%b exp=1111", Spectag_Valid); end
    total++; if (FreeSpectags !== 3'd0) begin bad++; $display("FAIL full_free got=%0d exp=0", FreeSpectags); end
    total++; if (ToAlloc_SpectagValid !== 2'b00) begin bad++; $display("FAIL full_slotvld got=%b exp=00", ToAlloc_SpectagValid); end
    total++; if (ToAlloc_Spectags !== 8'h00) begin bad++; $display("FAIL full_tags got=%b exp=00000000", ToAlloc_Spectags); end
    alloc(2'b11);
    total++; if (Spectag_Valid !== 4'b1111) begin bad++; $display("FAIL full_noalloc got=%b exp=1111", Spectag_Valid); end
    total++; if (dut.r_km[3] !== 4'b0111) begin bad++; $display("FAIL full_km3 got=%b exp=0111", dut.r_km[3]); end
    // oldest tag mispredicts: the whole chain goes
    FUBRresp = resp(1'b1, 4'b0001); tick(); idle_inputs();
    total++; if (Spectag_Valid !== 4'b0000) begin bad++; $display("FAIL full_killall got=%b exp=0000", Spectag_Valid); end
  endtask

  task automatic test_resolve_and_alloc();
    do_flush();
    alloc(2'b11);
    Alloced = 2'b01; FUBRresp = resp(1'b0, 4'b0001); tick(); idle_inputs();
    total++; if (Spectag_Valid !== 4'b0110) begin bad++; $display("FAIL ra_valid got=%b exp=0110", Spectag_Valid); end
    total++; if (dut.r_km[2] !== 4'b0010) begin bad++; $display("FAIL ra_km2 got=%b exp=0010", dut.r_km[2]); end
  endtask

  task automatic test_invalid_slot();
    do_flush();
    alloc(2'b11);
    alloc(2'b01);
    total++; if (ToAlloc_SpectagValid !== 2'b01) begin bad++; $display("FAIL inv_slotvld got=%b exp=01", ToAlloc_SpectagValid); end
    total++; if (ToAlloc_Spectags !== 8'b0000_1000) begin bad++; $display("FAIL inv_tags got=%b exp=00001000", ToAlloc_Spectags); end
    alloc(2'b11);
    total++; if (Spectag_Valid !== 4'b1111) begin bad++; $display("FAIL inv_valid got=%b exp=1111", Spectag_Valid); end
  endtask

  task automatic test_stall_flush();
    do_flush();
    alloc(2'b11);
    Stall = 1'b1; Alloced = 2'b01; FUBRresp = resp(1'b0, 4'b0001); tick(); idle_inputs();
    total++; if (Spectag_Valid !== 4'b0010) begin bad++; $display("FAIL stall_valid got=%b exp=0010", Spectag_Valid); end
    Flush = 1'b1; Alloced = 2'b11; FUBRresp = resp(1'b0, 4'b0010); tick(); idle_inputs();
    total++; if (Spectag_Valid !== 4'b0000) begin bad++; $display("FAIL flush_valid got=%b exp=0000", Spectag_Valid); end
    total++; if (dut.r_km[1] !== 4'b0000) begin bad++; $display("FAIL flush_km1 got=%b exp=0000", dut.r_km[1]); end
  endtask

  task automatic test_async_reset();
    alloc(2'b11);
    #2 rst = 1'b0;
    #1;
    total++; if (Spectag_Valid !== 4'b0000) begin bad++; $display("FAIL areset_valid got=%b exp=0000", Spectag_Valid); end
    rst = 1'b1;
    tick();
    total++; if (FreeSpectags !== 3'd4) begin bad++; $display("FAIL areset_free got=%0d exp=4", FreeSpectags); end
  endtask

  initial begin
    test_reset();
    test_alloc();
    test_correct_resolve();
    test_mispredict();
    test_full();
    test_resolve_and_alloc();
    test_invalid_slot();
    test_stall_flush();
    test_async_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
